// File: rtl/wb_ram_bridge.sv
// Wishbone slave in front of a sync-read byte-enabled single-port RAM.
// Optional read-burst prefetch: define WB_RAM_BRIDGE_BURST_EN.
module wb_ram_bridge #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int WB_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_cyc,
  input  logic                      wb_stb,
  input  logic                      wb_we,
  input  logic [WB_ADDR_WIDTH-1:0]  wb_adr,
  input  logic [DATA_WIDTH-1:0]     wb_dat_ms,
  input  logic [DATA_WIDTH/8-1:0]   wb_sel,
  input  logic [2:0]                wb_cti,
  input  logic [1:0]                wb_bte,
  output logic [DATA_WIDTH-1:0]     wb_dat_sm,
  output logic                      wb_ack,
  output logic                      wb_err,
  output logic [ADDR_WIDTH-1:0]     ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_wdata,
  output logic [DATA_WIDTH/8-1:0]   ram_be,
  output logic                      ram_we,
  input  logic [DATA_WIDTH-1:0]     ram_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    ERR
  } state_t;

  state_t state;
  state_t nxt;

  logic                  req;
  logic                  oor;
  logic [ADDR_WIDTH-1:0] word;
  logic                  unused;

  assign req    = wb_cyc & wb_stb;
  assign word   = wb_adr[ADDR_WIDTH+1:2];
  assign oor    = |wb_adr[WB_ADDR_WIDTH-1:ADDR_WIDTH+2];
  assign unused = ^{wb_adr[1:0], wb_cti, wb_bte};

`ifdef WB_RAM_BRIDGE_BURST_EN
  logic [WB_ADDR_WIDTH-3:0] nword;
  logic                     nxt_oor;
  logic                     burst;

  // next beat's range check, taken from the current beat's address
  assign nword   = wb_adr[WB_ADDR_WIDTH-1:2]
                 + {{(WB_ADDR_WIDTH-3){1'b0}}, 1'b1};
  assign nxt_oor = |nword[WB_ADDR_WIDTH-3:ADDR_WIDTH];
  assign burst   = req & ~wb_we
                 & (wb_cti == 3'b010)
                 & (wb_bte == 2'b00);
`endif

  assign ram_wdata = wb_dat_ms;
  assign ram_be    = wb_sel;
  assign wb_ack    = (state == ACK);
  assign wb_err    = (state == ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt       = state;
    ram_we    = 1'b0;
    ram_addr  = word;
    wb_dat_sm = '0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (oor) begin
            nxt = ERR;
          end else begin
            nxt    = ACK;
            ram_we = wb_we & ~rst;
          end
        end
      end
      ACK: begin
        nxt = IDLE;
        if (req & ~wb_we) wb_dat_sm = ram_rdata;
`ifdef WB_RAM_BRIDGE_BURST_EN
        // prefetch so the following beat can ack next cycle
        ram_addr = word + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        if (burst) nxt = nxt_oor ? ERR : ACK;
`endif
      end
      ERR:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_ram_bridge.sv
// Directed bench for wb_ram_bridge with a behavioural
// sync-read byte-enabled RAM model.
module tb_wb_ram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat_ms;
  logic [3:0]  wb_sel;
  logic [2:0]  wb_cti;
  logic [1:0]  wb_bte;
  logic [31:0] wb_dat_sm;
  logic        wb_ack, wb_err;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_be;
  logic        ram_we;
  logic [31:0] ram_rdata;

  logic [31:0] mem [1024];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  wb_ram_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .wb_cyc    (wb_cyc),
    .wb_stb    (wb_stb),
    .wb_we     (wb_we),
    .wb_adr    (wb_adr),
    .wb_dat_ms (wb_dat_ms),
    .wb_sel    (wb_sel),
    .wb_cti    (wb_cti),
    .wb_bte    (wb_bte),
    .wb_dat_sm (wb_dat_sm),
    .wb_ack    (wb_ack),
    .wb_err    (wb_err),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_be    (ram_be),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end else begin
      ram_rdata <= mem[ram_addr];
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        e_we0;
    logic [9:0]  e_addr;
    logic        e_ack;
    logic        e_err;
    logic [31:0] e_dat;
  } vec_t;

  typedef struct {
    logic        we0;
    logic [9:0]  addr0;
    logic        resp0;
    logic        ack1;
    logic        err1;
    logic [31:0] dat1;
    logic        we1;
  } obs_t;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic idle();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_adr = '0; wb_dat_ms = '0; wb_sel = '0;
    wb_cti = 3'b000; wb_bte = 2'b00;
  endtask

  // called at posedge+1; returns at posedge+1 with the bus idle
  task automatic xfer(input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel,
                      output obs_t o);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
    wb_adr = adr; wb_dat_ms = dat; wb_sel = sel;
    wb_cti = 3'b000; wb_bte = 2'b00;
    @(negedge clk);
    o.we0 = ram_we; o.addr0 = ram_addr; o.resp0 = wb_ack | wb_err;
    @(posedge clk); #1;
    @(negedge clk);
    o.ack1 = wb_ack; o.err1 = wb_err; o.dat1 = wb_dat_sm; o.we1 = ram_we;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic apply(input vec_t v, input string tag);
    obs_t o;
    xfer(v.we, v.adr, v.dat, v.sel, o);
    check({tag, "_we0"},  {31'd0, o.we0},   {31'd0, v.e_we0});
    check({tag, "_addr"}, {22'd0, o.addr0}, {22'd0, v.e_addr});
    check({tag, "_resp0"}, {31'd0, o.resp0}, 32'd0);
    check({tag, "_ack"},  {31'd0, o.ack1},  {31'd0, v.e_ack});
    check({tag, "_err"},  {31'd0, o.err1},  {31'd0, v.e_err});
    check({tag, "_dat"},  o.dat1,           v.e_dat);
    check({tag, "_we1"},  {31'd0, o.we1},   32'd0);
  endtask

  function automatic vec_t mk(logic we, logic [31:0] adr, logic [31:0] dat,
                              logic [3:0] sel, logic e_we0, logic [9:0] e_addr,
                              logic e_ack, logic e_err, logic [31:0] e_dat);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = dat; v.sel = sel;
    v.e_we0 = e_we0; v.e_addr = e_addr;
    v.e_ack = e_ack; v.e_err = e_err; v.e_dat = e_dat;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [14];
    obs_t o;
    int   exp_c [4];
    int   acks [$];
    int   beat;

    vt[0]  = mk(1, 32'h010, 32'hDEADBEEF, 4'hF, 1, 10'h004, 1, 0, 32'h0);
    vt[1]  = mk(0, 32'h010, 32'h0,        4'hF, 0, 10'h004, 1, 0, 32'hDEADBEEF);
    vt[2]  = mk(1, 32'h010, 32'h0000AB00, 4'h2, 1, 10'h004, 1, 0, 32'h0);
    vt[3]  = mk(0, 32'h010, 32'h0,        4'hF, 0, 10'h004, 1, 0, 32'hDEADABEF);
    vt[4]  = mk(0, 32'h1000, 32'h0,       4'hF, 0, 10'h000, 0, 1, 32'h0);
    vt[5]  = mk(1, 32'h1000, 32'h55AA55AA, 4'hF, 0, 10'h000, 0, 1, 32'h0);
    vt[6]  = mk(1, 32'hFFC, 32'h12345678, 4'hF, 1, 10'h3FF, 1, 0, 32'h0);
    vt[7]  = mk(0, 32'hFFC, 32'h0,        4'hF, 0, 10'h3FF, 1, 0, 32'h12345678);
    vt[8]  = mk(1, 32'h0F8, 32'h1,        4'hF, 1, 10'h03E, 1, 0, 32'h0);
    vt[9]  = mk(1, 32'h0FC, 32'h2,        4'hF, 1, 10'h03F, 1, 0, 32'h0);
    vt[10] = mk(1, 32'h100, 32'h3,        4'hF, 1, 10'h040, 1, 0, 32'h0);
    vt[11] = mk(1, 32'h104, 32'h4,        4'hF, 1, 10'h041, 1, 0, 32'h0);
    vt[12] = mk(0, 32'h104, 32'h0,        4'hF, 0, 10'h041, 1, 0, 32'h4);
    vt[13] = mk(0, 32'h010, 32'h0,        4'hF, 0, 10'h004, 1, 0, 32'hDEADABEF);

    idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", {31'd0, wb_ack}, 32'd0);
    check("rst_err", {31'd0, wb_err}, 32'd0);
    check("rst_dat", wb_dat_sm, 32'd0);
    check("rst_we",  {31'd0, ram_we}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) apply(vt[i], $sformatf("v%0d", i));

    // read burst from 0x0F8 over words 62..65
`ifdef WB_RAM_BRIDGE_BURST_EN
    exp_c = '{1, 2, 3, 4};
`else
    exp_c = '{1, 3, 5, 7};
`endif
    beat = 0;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 4'hF;
    wb_adr = 32'h0F8; wb_cti = 3'b010; wb_bte = 2'b00;
    for (int c = 0; c < 20 && beat < 4; c++) begin
      @(negedge clk);
      if (wb_ack) begin
        check($sformatf("burst_dat%0d", beat), wb_dat_sm, beat + 1);
        acks.push_back(c);
        beat++;
      end
      @(posedge clk); #1;
      if (beat < 4) begin
        wb_adr = 32'h0F8 + 32'(4 * beat);
        wb_cti = (beat == 3) ? 3'b111 : 3'b010;
      end else begin
        idle();
      end
    end
    idle();
    check("burst_beats", acks.size(), 4);
    for (int i = 0; i < acks.size() && i < 4; i++)
      check($sformatf("burst_cyc%0d", i), acks[i], exp_c[i]);
    @(negedge clk);
    check("burst_tail_ack", {31'd0, wb_ack}, 32'd0);
    @(posedge clk); #1;

    // reset while a read is in its ack cycle
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0;
    wb_adr = 32'h010; wb_sel = 4'hF;
    @(posedge clk); #1;
    check("rstmid_ack_before", {31'd0, wb_ack}, 32'd1);
    check("rstmid_dat_before", wb_dat_sm, 32'hDEADABEF);
    #1 rst = 1'b1;
    #1;
    check("rstmid_ack", {31'd0, wb_ack}, 32'd0);
    check("rstmid_dat", wb_dat_sm, 32'd0);
    wb_we = 1'b1; wb_dat_ms = 32'hFFFFFFFF;
    #1;
    check("rstmid_we", {31'd0, ram_we}, 32'd0);
    idle();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    apply(vt[13], "post_rst");

    // cyc dropped in the ack cycle of a burst
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 4'hF;
    wb_adr = 32'h0F8; wb_cti = 3'b010; wb_bte = 2'b00;
    @(posedge clk); #1;
    wb_cyc = 1'b0;
    @(negedge clk);
    check("drop_ack_c1", {31'd0, wb_ack}, 32'd1);
    check("drop_we_c1",  {31'd0, ram_we}, 32'd0);
    for (int c = 2; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("drop_ack_c%0d", c), {31'd0, wb_ack | wb_err}, 32'd0);
      check($sformatf("drop_we_c%0d", c),  {31'd0, ram_we}, 32'd0);
    end
    @(posedge clk); #1;
    idle();
    apply(vt[12], "post_drop");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
